// File: rtl/commit_queue_if.sv
// commit_queue_if: issue, writeback, commit and flush signals of the commit queue.
// The master side is the pipeline around the queue; the slave side is the queue itself.
interface commit_queue_if #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_WB_PORTS     = 4,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int XLEN            = 64,
   parameter int VLEN            = 39,
   parameter int TRANS_ID_BITS   = $clog2(NR_ENTRIES)
);
   logic                                           flush_i;
   logic                                           issue_valid_i;
   logic                                           issue_ready_o;
   logic [VLEN-1:0]                                issue_pc_i;
   logic [4:0]                                     issue_rd_i;
   logic [3:0]                                     issue_fu_i;
   logic [TRANS_ID_BITS-1:0]                       issue_trans_id_o;
   logic [NR_WB_PORTS-1:0]                         wb_valid_i;
   logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]      wb_trans_id_i;
   logic [NR_WB_PORTS-1:0][XLEN-1:0]               wb_data_i;
   logic [NR_WB_PORTS-1:0]                         wb_ex_valid_i;
   logic [NR_WB_PORTS-1:0][XLEN-1:0]               wb_ex_cause_i;
   logic [NR_COMMIT_PORTS-1:0]                     commit_valid_o;
   logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0]  commit_trans_id_o;
   logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]           commit_pc_o;
   logic [NR_COMMIT_PORTS-1:0][4:0]                commit_rd_o;
   logic [NR_COMMIT_PORTS-1:0][3:0]                commit_fu_o;
   logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]           commit_result_o;
   logic [NR_COMMIT_PORTS-1:0]                     commit_ex_valid_o;
   logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]           commit_ex_cause_o;
   logic [NR_COMMIT_PORTS-1:0]                     commit_ack_i;
   logic [TRANS_ID_BITS:0]                         count_o;

   modport master (
      output flush_i, issue_valid_i, issue_pc_i, issue_rd_i, issue_fu_i,
             wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_valid_i, wb_ex_cause_i,
             commit_ack_i,
      input  issue_ready_o, issue_trans_id_o, commit_valid_o, commit_trans_id_o,
             commit_pc_o, commit_rd_o, commit_fu_o, commit_result_o,
             commit_ex_valid_o, commit_ex_cause_o, count_o
   );

   modport slave (
      input  flush_i, issue_valid_i, issue_pc_i, issue_rd_i, issue_fu_i,
             wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_valid_i, wb_ex_cause_i,
             commit_ack_i,
      output issue_ready_o, issue_trans_id_o, commit_valid_o, commit_trans_id_o,
             commit_pc_o, commit_rd_o, commit_fu_o, commit_result_o,
             commit_ex_valid_o, commit_ex_cause_o, count_o
   );
endinterface

// File: rtl/commit_queue.sv
// commit_queue: in-order circular buffer upstream of commit. Hands out transaction IDs,
// collects writeback results/exceptions and retires the oldest done entries on ack.
module commit_queue #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_WB_PORTS     = 4,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int XLEN            = 64,
   parameter int VLEN            = 39,
   parameter int TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   commit_queue_if.slave bus
);
   localparam int                  CNT_BITS = TRANS_ID_BITS + 1;
   localparam logic [CNT_BITS-1:0] DEPTH    = CNT_BITS'(NR_ENTRIES);

   typedef logic [TRANS_ID_BITS-1:0] id_t;
   typedef logic [CNT_BITS-1:0]      cnt_t;

   typedef struct packed {
      logic [VLEN-1:0] pc;
      logic [4:0]      rd;
      logic [3:0]      fu;
      logic [XLEN-1:0] result;
      logic            ex_valid;
      logic [XLEN-1:0] ex_cause;
   } payload_t;

   payload_t                   payload_q [NR_ENTRIES];
   logic [NR_ENTRIES-1:0]      issued_q;
   logic [NR_ENTRIES-1:0]      done_q;
   id_t                        head_q;
   id_t                        tail_q;
   cnt_t                       count_q;

   logic                       issue_fire;
   id_t                        commit_id [NR_COMMIT_PORTS];
   logic [NR_COMMIT_PORTS-1:0] commit_valid;
   logic [NR_COMMIT_PORTS-1:0] retire;
   cnt_t                       n_retire;

   assign bus.issue_ready_o    = (count_q < DEPTH);
   assign issue_fire           = bus.issue_valid_i & bus.issue_ready_o;
   assign bus.issue_trans_id_o = tail_q;
   assign bus.count_o          = count_q;
   assign bus.commit_valid_o   = commit_valid;

   // Offer and retire chains: a port is live only if every older port is.
   always_comb begin
      logic valid_chain;
      logic retire_chain;
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      commit_valid = '0;
      retire       = '0;
      n_retire     = '0;
      valid_chain  = 1'b1;
      retire_chain = 1'b1;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         commit_id[k]    = head_q + id_t'(k);
         commit_valid[k] = valid_chain & issued_q[commit_id[k]] & done_q[commit_id[k]]
                           & (cnt_t'(k) < count_q);
         valid_chain     = commit_valid[k];
         retire[k]       = retire_chain & commit_valid[k] & bus.commit_ack_i[k];
         retire_chain    = retire[k];
         n_retire        = n_retire + cnt_t'(retire[k]);
      end
   end

   always_comb begin
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         bus.commit_trans_id_o[k] = commit_id[k];
         bus.commit_pc_o[k]       = payload_q[commit_id[k]].pc;
         bus.commit_rd_o[k]       = payload_q[commit_id[k]].rd;
         bus.commit_fu_o[k]       = payload_q[commit_id[k]].fu;
         bus.commit_result_o[k]   = payload_q[commit_id[k]].result;
         bus.commit_ex_valid_o[k] = payload_q[commit_id[k]].ex_valid;
         bus.commit_ex_cause_o[k] = payload_q[commit_id[k]].ex_cause;
      end
   end

   // Pointers and live bits; reset and flush outrank issue, writeback and ack.
   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush_i) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         issued_q <= '0;
         done_q   <= '0;
      end else begin
         for (int w = 0; w < NR_WB_PORTS; w++) begin
            if (bus.wb_valid_i[w] && issued_q[bus.wb_trans_id_i[w]]) begin
               done_q[bus.wb_trans_id_i[w]] <= 1'b1;
            end
         end
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (retire[k]) begin
               issued_q[commit_id[k]] <= 1'b0;
               done_q[commit_id[k]]   <= 1'b0;
            end
         end
         if (issue_fire) begin
            issued_q[tail_q] <= 1'b1;
            done_q[tail_q]   <= 1'b0;
         end
         head_q  <= head_q + id_t'(n_retire);
         tail_q  <= tail_q + id_t'(issue_fire);
         count_q <= count_q + cnt_t'(issue_fire) - n_retire;
      end
   end

   // NOTE: payload storage has no reset; issued/done alone decide which entries are live.
   always_ff @(posedge clk_i) begin
      // Ports scanned high-to-low so the lowest index is the last assignment and wins.
      for (int w = NR_WB_PORTS - 1; w >= 0; w--) begin
         if (bus.wb_valid_i[w] && issued_q[bus.wb_trans_id_i[w]]) begin
            payload_q[bus.wb_trans_id_i[w]].result   <= bus.wb_data_i[w];
            payload_q[bus.wb_trans_id_i[w]].ex_valid <= bus.wb_ex_valid_i[w];
            payload_q[bus.wb_trans_id_i[w]].ex_cause <= bus.wb_ex_cause_i[w];
         end
      end
      if (issue_fire) begin
         payload_q[tail_q].pc       <= bus.issue_pc_i;
         payload_q[tail_q].rd       <= bus.issue_rd_i;
         payload_q[tail_q].fu       <= bus.issue_fu_i;
         payload_q[tail_q].ex_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_commit_queue.sv
// tb_commit_queue: directed stimulus with a retire scoreboard; expected commit records are
// queued by the stimulus and popped by a monitor whenever the DUT retires an entry.
module tb_commit_queue;
   localparam int NE = 8;
   localparam int NW = 4;
   localparam int NC = 2;
   localparam int XL = 64;
   localparam int VL = 39;
   localparam int TB = 3;

   typedef struct packed {
      logic [TB-1:0] id;
      logic [VL-1:0] pc;
      logic [4:0]    rd;
      logic [3:0]    fu;
      logic [XL-1:0] result;
      logic          ex_valid;
      logic [XL-1:0] cause;
   } rec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   rec_t exp_q [$];

   commit_queue_if #(.NR_ENTRIES(NE), .NR_WB_PORTS(NW), .NR_COMMIT_PORTS(NC),
                     .XLEN(XL), .VLEN(VL), .TRANS_ID_BITS(TB)) bus ();

   commit_queue #(.NR_ENTRIES(NE), .NR_WB_PORTS(NW), .NR_COMMIT_PORTS(NC),
                  .XLEN(XL), .VLEN(VL), .TRANS_ID_BITS(TB)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush_i       = 1'b0;
      bus.issue_valid_i = 1'b0;
      bus.issue_pc_i    = '0;
      bus.issue_rd_i    = '0;
      bus.issue_fu_i    = '0;
      bus.wb_valid_i    = '0;
      bus.wb_trans_id_i = '0;
      bus.wb_data_i     = '0;
      bus.wb_ex_valid_i = '0;
      bus.wb_ex_cause_i = '0;
      bus.commit_ack_i  = '0;
   endtask

   task automatic issue(input logic [VL-1:0] pc, input logic [4:0] rd, input logic [3:0] fu,
                        input int exp_id);
      check("issue_id", 64'(bus.issue_trans_id_o), 64'(exp_id));
      bus.issue_valid_i = 1'b1;
      bus.issue_pc_i    = pc;
      bus.issue_rd_i    = rd;
      bus.issue_fu_i    = fu;
      tick();
      bus.issue_valid_i = 1'b0;
   endtask

   task automatic wb(input int port, input int id, input logic [XL-1:0] data,
                     input logic ex, input logic [XL-1:0] cause);
      bus.wb_valid_i[port]    = 1'b1;
      bus.wb_trans_id_i[port] = TB'(id);
      bus.wb_data_i[port]     = data;
      bus.wb_ex_valid_i[port] = ex;
      bus.wb_ex_cause_i[port] = cause;
   endtask

   function automatic rec_t mk(input int id, input logic [VL-1:0] pc, input int rd, input int fu,
                               input logic [XL-1:0] result, input logic ex,
                               input logic [XL-1:0] cause);
      mk = '{id: TB'(id), pc: pc, rd: 5'(rd), fu: 4'(fu), result: result,
             ex_valid: ex, cause: cause};
   endfunction

   // Retire monitor: walks the honoured-ack chain and checks each retired entry in order.
   always @(negedge clk) begin
      logic chain;
      rec_t act;
      rec_t exp;
      chain = 1'b1;
      if (!rst) begin
         for (int k = 0; k < NC; k++) begin
            chain = chain & bus.commit_valid_o[k] & bus.commit_ack_i[k];
            if (chain) begin
               act = '{id: bus.commit_trans_id_o[k], pc: bus.commit_pc_o[k],
                       rd: bus.commit_rd_o[k], fu: bus.commit_fu_o[k],
                       result: bus.commit_result_o[k], ex_valid: bus.commit_ex_valid_o[k],
                       cause: bus.commit_ex_cause_o[k]};
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL retire_unexpected: got id %0h pc %0h with nothing expected",
                           act.id, act.pc);
               end else begin
                  exp = exp_q.pop_front();
                  if (act !== exp) begin
                     bad++;
                     $display("FAIL retire_rec: got id=%0h pc=%0h rd=%0h fu=%0h res=%0h ex=%0b cause=%0h expected id=%0h pc=%0h rd=%0h fu=%0h res=%0h ex=%0b cause=%0h",
                              act.id, act.pc, act.rd, act.fu, act.result, act.ex_valid, act.cause,
                              exp.id, exp.pc, exp.rd, exp.fu, exp.result, exp.ex_valid, exp.cause);
                  end
               end
            end
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", 64'(bus.issue_ready_o), 64'd1);
      check("rst_count", 64'(bus.count_o), 64'd0);
      check("rst_id", 64'(bus.issue_trans_id_o), 64'd0);
      check("rst_cv", 64'(bus.commit_valid_o), 64'd0);

      // Three issues, then a writeback to a never-issued slot.
      for (int i = 0; i < 3; i++) issue(VL'(32'h1000 + 4 * i), 5'(i + 1), 4'(i), i);
      check("cnt3", 64'(bus.count_o), 64'd3);
      check("cv_none", 64'(bus.commit_valid_o), 64'd0);
      wb(0, 5, 64'hDEAD, 1'b0, '0);
      tick();
      idle();
      check("wb_unissued_cnt", 64'(bus.count_o), 64'd3);
      check("wb_unissued_cv", 64'(bus.commit_valid_o), 64'd0);

      // Younger done entry is held until the older one completes.
      wb(0, 1, 64'hAA, 1'b0, '0);
      tick();
      idle();
      check("cv_older_pending", 64'(bus.commit_valid_o), 64'b00);
      wb(0, 0, 64'h55, 1'b0, '0);
      tick();
      idle();
      check("cv_both", 64'(bus.commit_valid_o), 64'b11);
      check("res0", bus.commit_result_o[0], 64'h55);
      check("res1", bus.commit_result_o[1], 64'hAA);
      bus.commit_ack_i = 2'b10;
      tick();
      idle();
      check("ack10_cnt", 64'(bus.count_o), 64'd3);
      check("ack10_cv", 64'(bus.commit_valid_o), 64'b11);
      exp_q.push_back(mk(0, VL'(32'h1000), 1, 0, 64'h55, 1'b0, '0));
      exp_q.push_back(mk(1, VL'(32'h1004), 2, 1, 64'hAA, 1'b0, '0));
      bus.commit_ack_i = 2'b11;
      tick();
      idle();
      check("ack11_cnt", 64'(bus.count_o), 64'd1);
      check("head_id2", 64'(bus.commit_trans_id_o[0]), 64'd2);
      check("head_cv", 64'(bus.commit_valid_o), 64'b00);

      // Mid-operation reset, then fill and retire-while-full.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_count", 64'(bus.count_o), 64'd0);
      for (int j = 0; j < NE; j++) issue(VL'(32'h2000 + 4 * j), 5'(j), 4'(j), j);
      check("full_ready", 64'(bus.issue_ready_o), 64'd0);
      check("full_count", 64'(bus.count_o), 64'd8);
      check("full_id", 64'(bus.issue_trans_id_o), 64'd0);
      wb(0, 0, 64'h77, 1'b0, '0);
      tick();
      idle();
      check("full_cv", 64'(bus.commit_valid_o), 64'b01);
      exp_q.push_back(mk(0, VL'(32'h2000), 0, 0, 64'h77, 1'b0, '0));
      bus.commit_ack_i  = 2'b01;
      bus.issue_valid_i = 1'b1;
      bus.issue_pc_i    = VL'(32'h3000);
      bus.issue_rd_i    = 5'd9;
      bus.issue_fu_i    = 4'd9;
      tick();
      bus.commit_ack_i = '0;
      check("retire_full_cnt", 64'(bus.count_o), 64'd7);
      check("retire_full_ready", 64'(bus.issue_ready_o), 64'd1);
      check("wrap_id", 64'(bus.issue_trans_id_o), 64'd0);
      tick();
      idle();
      check("refill_cnt", 64'(bus.count_o), 64'd8);
      check("refill_ready", 64'(bus.issue_ready_o), 64'd0);
      check("refill_id", 64'(bus.issue_trans_id_o), 64'd1);

      // Same-ID writeback on ports 0 and 2: port 0 must win.
      wb(0, 3, 64'h11, 1'b0, '0);
      wb(2, 3, 64'h22, 1'b0, '0);
      wb(1, 1, 64'h101, 1'b0, '0);
      wb(3, 2, 64'h102, 1'b0, '0);
      tick();
      idle();
      check("multi_cv", 64'(bus.commit_valid_o), 64'b11);
      check("multi_head", 64'(bus.commit_trans_id_o[0]), 64'd1);
      exp_q.push_back(mk(1, VL'(32'h2004), 1, 1, 64'h101, 1'b0, '0));
      exp_q.push_back(mk(2, VL'(32'h2008), 2, 2, 64'h102, 1'b0, '0));
      bus.commit_ack_i = 2'b11;
      tick();
      idle();
      check("multi_cnt", 64'(bus.count_o), 64'd6);
      check("id3_head", 64'(bus.commit_trans_id_o[0]), 64'd3);
      check("id3_cv", 64'(bus.commit_valid_o), 64'b01);
      check("id3_res", bus.commit_result_o[0], 64'h11);
      exp_q.push_back(mk(3, VL'(32'h200C), 3, 3, 64'h11, 1'b0, '0));
      bus.commit_ack_i = 2'b01;
      tick();
      idle();
      check("id3_cnt", 64'(bus.count_o), 64'd5);

      // Flush, then an exception entry followed by a flush racing issue and writeback.
      bus.flush_i = 1'b1;
      tick();
      idle();
      check("flush_cnt", 64'(bus.count_o), 64'd0);
      check("flush_id", 64'(bus.issue_trans_id_o), 64'd0);
      check("flush_ready", 64'(bus.issue_ready_o), 64'd1);
      issue(VL'(32'h4000), 5'd5, 4'd4, 0);
      issue(VL'(32'h4004), 5'd6, 4'd4, 1);
      wb(1, 0, 64'h0, 1'b1, 64'h2);
      tick();
      idle();
      check("ex_cv", 64'(bus.commit_valid_o), 64'b01);
      check("ex_valid", 64'(bus.commit_ex_valid_o[0]), 64'd1);
      check("ex_cause", bus.commit_ex_cause_o[0], 64'h2);
      exp_q.push_back(mk(0, VL'(32'h4000), 5, 4, 64'h0, 1'b1, 64'h2));
      bus.commit_ack_i = 2'b01;
      tick();
      idle();
      check("ex_cnt", 64'(bus.count_o), 64'd1);
      bus.flush_i       = 1'b1;
      bus.issue_valid_i = 1'b1;
      bus.issue_pc_i    = VL'(32'h5000);
      wb(0, 1, 64'h99, 1'b0, '0);
      tick();
      idle();
      check("flush_race_cnt", 64'(bus.count_o), 64'd0);
      check("flush_race_id", 64'(bus.issue_trans_id_o), 64'd0);
      check("flush_race_cv", 64'(bus.commit_valid_o), 64'b00);
      tick();
      check("flush_after_cv", 64'(bus.commit_valid_o), 64'b00);
      check("flush_after_cnt", 64'(bus.count_o), 64'd0);

      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
